// File: rtl/bus_arb_pkg.sv
// Shared types and sizing for the coherence-bus request arbiter.
// Sizing is set here; NREQ = L1 requesters (I$+D$ per hart) plus one page walker per hart.
package bus_arb_pkg;

    localparam int NUM_HARTS = 1;
    localparam int CPUS      = 2 * NUM_HARTS;
    localparam int NREQ      = CPUS + NUM_HARTS;
    localparam int ID_W      = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        GNT_NONE,
        GNT_R,
        GNT_RX,
        GNT_INV,
        GNT_EVICT,
        GNT_PW
    } bus_gnt_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWNED,
        ARB_HOLDOFF
    } arb_state_t;

    // Round-robin pointer successor, wrapping NREQ-1 -> 0.
    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] idx);
        return (idx == ID_W'(NREQ - 1)) ? '0 : idx + ID_W'(1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority picker: first set request at or after start,
// wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N = 3,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [N-1:0] upper;
    logic [N-1:0] req_hi;
    logic [N-1:0] pick_src;

    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign upper[gi] = (W'(gi) >= start);
    end

    // Search the upper part first; if empty, the wrapped search is the lowest set bit overall.
    assign req_hi   = req & upper;
    assign pick_src = (|req_hi) ? req_hi : req;
    assign onehot   = pick_src & (~pick_src + N'(1));
    assign any      = |req;

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_req_arbiter.sv
// Round-robin arbiter sharing the coherence bus controller between L1s and page walkers.
// Optional BUS_ARB_PW_PRIORITY_EN: walkers win over L1s, with a forced L1 grant after 8 walker grants.
module bus_req_arbiter
    import bus_arb_pkg::*;
(
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS-1:0]      ccwrite,
    input  logic [CPUS-1:0]      ccabort,
    input  logic [NUM_HARTS-1:0] pREN,
    input  logic                 bus_idle,
    input  logic                 txn_done,
    output logic                 gnt_valid,
    output logic [NREQ-1:0]      gnt_onehot,
    output logic [ID_W-1:0]      gnt_id,
    output bus_gnt_t             gnt_type,
    output logic                 gnt_start
);

    arb_state_t      state_reg, state_next;
    logic [ID_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [NREQ-1:0] onehot_reg, onehot_next;
    logic [ID_W-1:0] id_reg, id_next;
    bus_gnt_t        type_reg, type_next;
    logic            start_reg, start_next;

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] win_oh;
    logic [ID_W-1:0] win_idx;
    logic            win_any;
    bus_gnt_t        win_type;
    logic            abort_hit;

    for (genvar gi = 0; gi < CPUS; gi++) begin : g_l1_req
        assign req[gi] = dREN[gi] | dWEN[gi] | (ccwrite[gi] & ~dREN[gi]);
    end
    assign req[NREQ-1:CPUS] = pREN;

`ifdef BUS_ARB_PW_PRIORITY_EN
    localparam logic [3:0] PW_FORCE_L1 = 4'd8;

    logic [NREQ-1:0]      l1_req, l1_oh;
    logic [ID_W-1:0]      l1_idx;
    logic                 l1_any;
    logic [NUM_HARTS-1:0] pw_req, pw_oh;
    logic [ID_W-1:0]      pw_idx;
    logic [3:0]           pw_cnt_reg, pw_cnt_next;
    logic                 force_l1;

    assign l1_req = req & {{NUM_HARTS{1'b0}}, {CPUS{1'b1}}};

    rr_pick #(.N(NREQ), .W(ID_W)) u_l1_pick (
        .req    (l1_req),
        .start  (rr_ptr_reg),
        .onehot (l1_oh),
        .idx    (l1_idx),
        .any    (l1_any)
    );

    // Walkers use fixed priority, lowest hart first.
    assign pw_req = req[NREQ-1:CPUS];
    assign pw_oh  = pw_req & (~pw_req + NUM_HARTS'(1));

    always_comb begin
        pw_idx = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (pw_oh[h]) begin
                pw_idx = ID_W'(CPUS + h);
            end
        end
    end

    assign force_l1 = (pw_cnt_reg >= PW_FORCE_L1) && l1_any;

    always_comb begin
        if ((|pw_req) && !force_l1) begin
            win_oh  = {pw_oh, {CPUS{1'b0}}};
            win_idx = pw_idx;
            win_any = 1'b1;
        end else begin
            win_oh  = l1_oh;
            win_idx = l1_idx;
            win_any = l1_any;
        end
    end
`else
    rr_pick #(.N(NREQ), .W(ID_W)) u_rr_pick (
        .req    (req),
        .start  (rr_ptr_reg),
        .onehot (win_oh),
        .idx    (win_idx),
        .any    (win_any)
    );
`endif

    always_comb begin
        win_type = GNT_NONE;
        for (int i = 0; i < CPUS; i++) begin
            if (win_oh[i]) begin
                if (dWEN[i])                    win_type = GNT_EVICT;
                else if (dREN[i] & ccwrite[i])  win_type = GNT_RX;
                else if (dREN[i])               win_type = GNT_R;
                else                            win_type = GNT_INV;
            end
        end
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (win_oh[CPUS + h]) begin
                win_type = GNT_PW;
            end
        end
    end

    // Only an L1 owner can abort; walkers have no abort line.
    assign abort_hit = |(onehot_reg[CPUS-1:0] & ccabort);

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        onehot_next = onehot_reg;
        id_next     = id_reg;
        type_next   = type_reg;
        start_next  = 1'b0;
`ifdef BUS_ARB_PW_PRIORITY_EN
        pw_cnt_next = pw_cnt_reg;
`endif
        case (state_reg)
            ARB_IDLE: begin
                if (win_any && bus_idle) begin
                    state_next  = ARB_OWNED;
                    onehot_next = win_oh;
                    id_next     = win_idx;
                    type_next   = win_type;
                    start_next  = 1'b1;
`ifdef BUS_ARB_PW_PRIORITY_EN
                    if (|win_oh[CPUS-1:0]) begin
                        rr_ptr_next = next_ptr(win_idx);
                        pw_cnt_next = '0;
                    end else if (pw_cnt_reg != 4'hF) begin
                        pw_cnt_next = pw_cnt_reg + 4'd1;
                    end
`else
                    rr_ptr_next = next_ptr(win_idx);
`endif
                end
            end
            ARB_OWNED: begin
                if (txn_done || abort_hit) begin
                    state_next  = ARB_HOLDOFF;
                    onehot_next = '0;
                    id_next     = '0;
                    type_next   = GNT_NONE;
                end
            end
            ARB_HOLDOFF: state_next = ARB_IDLE;
            default:     state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg  <= ARB_IDLE;
            rr_ptr_reg <= '0;
            onehot_reg <= '0;
            id_reg     <= '0;
            type_reg   <= GNT_NONE;
            start_reg  <= 1'b0;
`ifdef BUS_ARB_PW_PRIORITY_EN
            pw_cnt_reg <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            onehot_reg <= onehot_next;
            id_reg     <= id_next;
            type_reg   <= type_next;
            start_reg  <= start_next;
`ifdef BUS_ARB_PW_PRIORITY_EN
            pw_cnt_reg <= pw_cnt_next;
`endif
        end
    end

    assign gnt_valid  = (state_reg == ARB_OWNED);
    assign gnt_onehot = onehot_reg;
    assign gnt_id     = id_reg;
    assign gnt_type   = type_reg;
    assign gnt_start  = start_reg;

endmodule

// File: tb/tb_bus_req_arbiter.sv
// Bench for bus_req_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_bus_req_arbiter;
    import bus_arb_pkg::*;

    logic                 CLK = 1'b0;
    logic                 nRST;
    logic [CPUS-1:0]      dREN, dWEN, ccwrite, ccabort;
    logic [NUM_HARTS-1:0] pREN;
    logic                 bus_idle, txn_done;
    logic                 gnt_valid, gnt_start;
    logic [NREQ-1:0]      gnt_onehot;
    logic [ID_W-1:0]      gnt_id;
    bus_gnt_t             gnt_type;

    int total = 0;
    int bad   = 0;

    // Model state: who owns the bus, whether we are in the one-cycle gap, and the search origin.
    int m_valid, m_start, m_id, m_type, m_ptr, m_gap, m_pwcnt;

    bus_req_arbiter dut (
        .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .ccwrite(ccwrite),
        .ccabort(ccabort), .pREN(pREN), .bus_idle(bus_idle), .txn_done(txn_done),
        .gnt_valid(gnt_valid), .gnt_onehot(gnt_onehot), .gnt_id(gnt_id),
        .gnt_type(gnt_type), .gnt_start(gnt_start)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit requesting(int i);
        if (i < CPUS) return dREN[i] | dWEN[i] | ccwrite[i];
        return pREN[i - CPUS];
    endfunction

    function automatic int kind_of(int i);
        if (i >= CPUS)              return int'(GNT_PW);
        if (dWEN[i])                return int'(GNT_EVICT);
        if (dREN[i] && ccwrite[i])  return int'(GNT_RX);
        if (dREN[i])                return int'(GNT_R);
        return int'(GNT_INV);
    endfunction

    function automatic int search_from(int from, bit l1_only);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (from + k) % NREQ;
            if (!(l1_only && i >= CPUS) && requesting(i)) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_start = 0; m_id = 0; m_type = int'(GNT_NONE);
        m_ptr = 0; m_gap = 0; m_pwcnt = 0;
    endtask

    task automatic model_step();
        int w;
        m_start = 0;
        if (m_gap != 0) begin
            m_gap = 0;
        end else if (m_valid != 0) begin
            if (txn_done || (m_id < CPUS && ccabort[m_id])) begin
                m_valid = 0;
                m_gap   = 1;
            end
        end else if (bus_idle) begin
`ifdef BUS_ARB_PW_PRIORITY_EN
            w = -1;
            if (!(m_pwcnt >= 8 && search_from(0, 1) >= 0)) begin
                for (int h = NUM_HARTS - 1; h >= 0; h--) if (pREN[h]) w = CPUS + h;
            end
            if (w < 0) w = search_from(m_ptr, 1);
`else
            w = search_from(m_ptr, 0);
`endif
            if (w >= 0) begin
                m_valid = 1; m_start = 1; m_id = w; m_type = kind_of(w);
`ifdef BUS_ARB_PW_PRIORITY_EN
                if (w < CPUS) begin
                    m_ptr = (w + 1) % NREQ;
                    m_pwcnt = 0;
                end else if (m_pwcnt < 15) begin
                    m_pwcnt++;
                end
`else
                m_ptr = (w + 1) % NREQ;
`endif
            end
        end
    endtask

    task automatic compare();
        check("valid", gnt_valid, m_valid);
        check("start", gnt_start, m_start);
        if (m_valid != 0) begin
            check("id", gnt_id, m_id);
            check("onehot", gnt_onehot, 32'd1 << m_id);
            check("type", gnt_type, m_type);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        compare();
    endtask

    task automatic clear_inputs();
        dREN = '0; dWEN = '0; ccwrite = '0; ccabort = '0; pREN = '0;
        bus_idle = 1'b1; txn_done = 1'b0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge CLK);
        check("rst_valid", gnt_valid, 0);
        check("rst_onehot", gnt_onehot, 0);
        check("rst_id", gnt_id, 0);
        check("rst_type", gnt_type, GNT_NONE);
        check("rst_start", gnt_start, 0);
        nRST = 1'b1;
    endtask

    task automatic wait_grant(input string name, input int exp_id, input int exp_type);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!gnt_start && n < 20);
        if (!gnt_start) begin
            total++; bad++;
            $display("FAIL %s: no grant within 20 cycles", name);
        end else begin
            check(name, gnt_id, exp_id);
            check(name, gnt_type, exp_type);
            $display("grant %s: id=%0d type=%0d", name, gnt_id, gnt_type);
        end
    endtask

    task automatic finish_txn();
        repeat (2) tick();
        txn_done = 1'b1;
        tick();
        txn_done = 1'b0;
        check("holdoff_valid", gnt_valid, 0);
    endtask

    initial begin
        int seq [6];
        nRST = 1'b0;
        clear_inputs();
        model_reset();

        // Single requester, basic handshake.
        do_reset();
        dREN = 2'b01;
        tick();
        check("t1_valid", gnt_valid, 1);
        check("t1_id", gnt_id, 0);
        check("t1_type", gnt_type, GNT_R);
        check("t1_start", gnt_start, 1);
        tick();
        check("t1_start_drop", gnt_start, 0);
        check("t1_held", gnt_valid, 1);
        txn_done = 1'b1;
        tick();
        txn_done = 1'b0;
        dREN = '0;
        check("t1_holdoff", gnt_valid, 0);
        tick();
        check("t1_idle", gnt_valid, 0);
        $display("txn basic done");

        // Everyone requesting continuously.
        do_reset();
        dREN = 2'b11;
        pREN = 1'b1;
`ifdef BUS_ARB_PW_PRIORITY_EN
        seq = '{2, 2, 2, 2, 2, 2};
`else
        seq = '{0, 1, 2, 0, 1, 2};
`endif
        for (int g = 0; g < 6; g++) begin
            wait_grant("rotate", seq[g], (seq[g] < CPUS) ? int'(GNT_R) : int'(GNT_PW));
            finish_txn();
        end

        // Grant type classification.
        do_reset();
        dREN = 2'b10; ccwrite = 2'b10;
        wait_grant("type_rx", 1, GNT_RX);
        finish_txn();
        do_reset();
        ccwrite = 2'b01;
        wait_grant("type_inv", 0, GNT_INV);
        finish_txn();
        do_reset();
        dWEN = 2'b01; dREN = 2'b01;
        wait_grant("type_evict", 0, GNT_EVICT);
        finish_txn();

        // Abort by the owning L1, pending walker wins next.
        do_reset();
        dREN = 2'b10;
        wait_grant("abort_own", 1, GNT_R);
        pREN = 1'b1;
        tick();
        ccabort = 2'b10;
        tick();
        ccabort = '0;
        dREN = '0;
        check("abort_drop", gnt_valid, 0);
        wait_grant("abort_next", 2, GNT_PW);
        finish_txn();

        // Bus busy: nothing granted, pointer untouched; then async reset while owned.
        do_reset();
        bus_idle = 1'b0;
        dREN = 2'b11; pREN = 1'b1;
        repeat (5) tick();
        check("busy_nogrant", gnt_valid, 0);
        bus_idle = 1'b1;
`ifdef BUS_ARB_PW_PRIORITY_EN
        wait_grant("busy_then", 2, GNT_PW);
`else
        wait_grant("busy_then", 0, GNT_R);
`endif
        #2 nRST = 1'b0;
        #1;
        check("arst_valid", gnt_valid, 0);
        check("arst_onehot", gnt_onehot, 0);
        check("arst_id", gnt_id, 0);
        check("arst_type", gnt_type, GNT_NONE);
        check("arst_start", gnt_start, 0);
        model_reset();
        clear_inputs();
        @(negedge CLK);
        nRST = 1'b1;

`ifdef BUS_ARB_PW_PRIORITY_EN
        // Walker burst limit: 8 walker grants, one forced L1 grant, then walkers again.
        do_reset();
        pREN = 1'b1; dREN = 2'b01;
        for (int g = 0; g < 10; g++) begin
            wait_grant("pw_burst", (g == 8) ? 0 : 2, (g == 8) ? int'(GNT_R) : int'(GNT_PW));
            finish_txn();
        end
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            dREN     = CPUS'($urandom);
            dWEN     = ($urandom_range(0, 3) == 0) ? CPUS'($urandom) : '0;
            ccwrite  = ($urandom_range(0, 2) == 0) ? CPUS'($urandom) : '0;
            ccabort  = ($urandom_range(0, 9) == 0) ? CPUS'($urandom) : '0;
            pREN     = NUM_HARTS'($urandom);
            bus_idle = ($urandom_range(0, 4) != 0);
            txn_done = ($urandom_range(0, 3) == 0);
            tick();
            if (gnt_start) $display("rand grant: id=%0d type=%0d", gnt_id, gnt_type);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
